// File: rtl/sd_save_drain.sv
// sd_save_drain
// Consumer side of the save-path sample FIFO. Waits for a full sector of
// samples, issues one sector write to the SD write controller, then feeds the
// controller one 16-bit word per request. Sector addresses advance from
// START_SEC. Once MAX_SECTORS sectors are done the block parks in STOP until
// reset. If a word is requested while the FIFO is empty, the block sends zero
// and sets a sticky underrun flag.
module sd_save_drain #(
  parameter logic [31:0] START_SEC   = 32'd2000,
  parameter int unsigned SEC_WORDS   = 256,
  parameter logic [31:0] MAX_SECTORS = 32'd1024
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        fifo_prog_full,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_rd_data,
  output logic        fifo_rd_en,
  input  logic        sd_wr_busy,
  input  logic        sd_wr_req,
  output logic        sd_wr_start_en,
  output logic [31:0] sd_wr_sec_addr,
  output logic [15:0] sd_wr_data,
  output logic [31:0] sectors_done,
  output logic        underrun,
  output logic        drain_finish
);

  // One extra bit so the counter can hold SEC_WORDS itself if ever needed.
  localparam int unsigned       CNT_W     = $clog2(SEC_WORDS) + 1;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(SEC_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_START     = 3'd2,
    S_XFER      = 3'd3,
    S_DONE_WAIT = 3'd4,
    S_STOP      = 3'd5
  } state_e;

  // Sequencer state and registered outputs
  state_e           state_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             start_en_q;
  logic [31:0]      sec_addr_q;
  logic [31:0]      sectors_q;
  logic             finish_q;

  // Word delivery path
  logic             cap_pend_q;
  logic             cap_zero_q;
  logic [15:0]      wr_data_q;
  logic             underrun_q;

  // Combinational decode
  logic             xfer_req_s;
  logic             pop_s;
  logic             last_word_s;
  logic             stop_s;
  logic [31:0]      sec_addr_d;
  logic [31:0]      sectors_d;

  // Qualify requests by state, gate pops on FIFO occupancy, and precompute sector-end terms.
  always_comb begin
    xfer_req_s  = 1'b0;
    pop_s       = 1'b0;
    last_word_s = 1'b0;
    stop_s      = 1'b0;
    sec_addr_d  = sec_addr_q + 32'd1;
    sectors_d   = sectors_q + 32'd1;

    // Requests only mean something while a sector is being transferred.
    if (state_q == S_XFER) begin
      xfer_req_s = sd_wr_req;
    end else begin
      xfer_req_s = 1'b0;
    end

    // Never pop an empty FIFO: an underrun is answered with zero instead.
    if (xfer_req_s && !fifo_empty) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end

    last_word_s = (word_cnt_q == LAST_WORD);

    // Sector limit of zero means run forever.
    if (MAX_SECTORS != 32'd0) begin
      stop_s = (sectors_d == MAX_SECTORS);
    end else begin
      stop_s = 1'b0;
    end
  end

  // Sector sequencer: state, start pulse, word counter, address and sector counters.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= CNT_ZERO;
      start_en_q <= 1'b0;
      sec_addr_q <= START_SEC;
      sectors_q  <= 32'd0;
      finish_q   <= 1'b0;
    end else begin
      start_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sd_init_done) begin
            state_q <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          // Losing the card takes priority over starting a new sector.
          if (!sd_init_done) begin
            state_q <= S_IDLE;
          end else if (fifo_prog_full && !sd_wr_busy) begin
            state_q    <= S_START;
            start_en_q <= 1'b1;
          end
        end
        S_START: begin
          word_cnt_q <= CNT_ZERO;
          state_q    <= S_XFER;
        end
        S_XFER: begin
          if (sd_wr_req) begin
            word_cnt_q <= word_cnt_q + CNT_ONE;
            if (last_word_s) begin
              state_q <= S_DONE_WAIT;
            end
          end
        end
        S_DONE_WAIT: begin
          // The sector counts as done only once the controller has finished writing it.
          if (!sd_wr_busy) begin
            sec_addr_q <= sec_addr_d;
            sectors_q  <= sectors_d;
            if (stop_s) begin
              state_q  <= S_STOP;
              finish_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_DATA;
            end
          end
        end
        S_STOP: begin
          finish_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Load the popped word (or zero on underrun) the cycle after the FIFO presents it.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cap_pend_q <= 1'b0;
      cap_zero_q <= 1'b0;
      wr_data_q  <= 16'h0000;
      underrun_q <= 1'b0;
    end else begin
      cap_pend_q <= xfer_req_s;
      cap_zero_q <= xfer_req_s & fifo_empty;
      if (xfer_req_s && fifo_empty) begin
        underrun_q <= 1'b1;
      end
      if (cap_pend_q) begin
        wr_data_q <= cap_zero_q ? 16'h0000 : fifo_rd_data;
      end
    end
  end

  assign fifo_rd_en     = pop_s;
  assign sd_wr_start_en = start_en_q;
  assign sd_wr_sec_addr = sec_addr_q;
  assign sd_wr_data     = wr_data_q;
  assign sectors_done   = sectors_q;
  assign underrun       = underrun_q;
  assign drain_finish   = finish_q;

endmodule
